prio_arb_n: RTL

Parametrised, registered N-input priority arbiter. It is the sequential successor of the 4-to-2 priority encoder. It accepts N request lines, picks one winner by fixed MSB-first priority or by round-robin, and holds a one-hot grant plus encoded index until the owner releases. An optional hold-timeout forcibly revokes the grant. It sits between multiple requesters and a single shared resource (bus, port, memory bank).

---
 rtl/prio_arb_n.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/prio_arb_n.sv
// prio_arb_n -- registered N-input priority arbiter.
//
// Picks one requester out of N and holds a one-hot grant, plus its binary
// index, until the owner releases. The owner releases by pulsing done or by
// dropping its request. An optional hold timeout forcibly revokes the grant.
// Winner selection is one of two modes:
//   - fixed priority: the highest index wins
//   - round-robin: the search starts at a rotating pointer
// Every output comes straight from a flop. There is always at least one idle
// cycle between two consecutive owners.
//
// Parameters:
//   N        number of request channels (2..32)
//   RR       0 = fixed priority, 1 = round-robin
//   TIMEOUT  maximum grant hold in cycles, 0 disables (0..65535)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        level-sensitive request lines, bit i = channel i
//   done       current owner releases the grant
//   gnt        one-hot grant (registered)
//   gnt_idx    binary index of the granted channel (registered)
//   gnt_valid  high while a grant is held
//   timeout    one-cycle pulse when a grant was revoked by the timeout
module prio_arb_n #(
  parameter  int N       = 8,
  parameter  int RR      = 0,
  parameter  int TIMEOUT = 0,
  localparam int IDXW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Last value of the hold counter. With the timeout disabled, the counter
  // just saturates at all-ones and is never compared against.
  localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'hFFFF : 16'(TIMEOUT - 1);
  localparam logic [IDXW:0] N_W = (IDXW + 1)'(N);

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] win_next;
  logic [N-1:0]    rot_req;
  logic [IDXW-1:0] rot_off;
  logic [IDXW:0]   rr_sum;
  logic [IDXW:0]   next_sum;

  // Winner selection.
  // In fixed mode, the loop keeps overwriting, so the highest set bit wins.
  // In round-robin mode, the request vector is rotated so that the pointer
  // sits at bit 0. The lowest set bit of the rotated vector is then the
  // first requester at or after the pointer. That offset is added back to
  // the pointer, modulo N.
  always_comb begin
    win_idx = '0;
    rot_req = N'({req, req} >> ptr_q);
    rot_off = '0;
    rr_sum  = '0;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win_idx = IDXW'(i);
      end
    end else begin
      for (int j = N - 1; j >= 0; j--) begin
        if (rot_req[j]) rot_off = IDXW'(j);
      end
      rr_sum = {1'b0, ptr_q} + {1'b0, rot_off};
      if (rr_sum >= N_W) rr_sum = rr_sum - N_W;
      win_idx = rr_sum[IDXW-1:0];
    end
  end

  // Pointer value after granting win_idx: one past the winner, wrapping at N.
  always_comb begin
    next_sum = {1'b0, win_idx} + {{IDXW{1'b0}}, 1'b1};
    if (next_sum == N_W) next_sum = '0;
    win_next = next_sum[IDXW-1:0];
  end

  // Next-state logic.
  // Done and owner drop both count as a normal release, so the timeout flag
  // only pulses when the counter expiry is the sole reason for releasing.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = HOLD;
          gnt_d       = N'(1) << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          if (RR != 0) ptr_d = win_next;
        end
      end
      HOLD: begin
        if (done || !req[gnt_idx_q] || ((TIMEOUT != 0) && (cnt_q == CNT_LAST))) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !done && req[gnt_idx_q];
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs live here. Reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
